// File: rtl/dcache_pkg.sv
// ----------------------------------------------------------------------------
// dcache_pkg
// Shared widths, SRAM tag-word layout and miss-controller state encoding for
// the 2-way data cache miss controller (16 sets, 256-bit lines).
// ----------------------------------------------------------------------------
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = 256;
    localparam int OFF_W      = 5;
    localparam int IDX_W      = 4;
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;  // 23
    localparam int SRAM_TAG_W = TAG_W + 2;               // {valid, dirty, tag}
    localparam int WSEL_W     = 3;                       // word within a line
    localparam int LADDR_W    = ADDR_W - OFF_W;          // line address {tag, index}

    // Bit positions inside the SRAM tag word
    localparam int TAG_VALID_BIT = 24;
    localparam int TAG_DIRTY_BIT = 23;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_MISS        = 3'd1,
        ST_WRITEBACK   = 3'd2,
        ST_REFILL      = 3'd3,
        ST_REFILL_DONE = 3'd4
    } state_e;

    // Assemble an SRAM tag word from its fields
    function automatic logic [SRAM_TAG_W-1:0] make_tag(
        input logic             valid,
        input logic             dirty,
        input logic [TAG_W-1:0] tag
    );
        return {valid, dirty, tag};
    endfunction

endpackage

// File: rtl/dcache_word_sel.sv
// ----------------------------------------------------------------------------
// dcache_word_sel
// Combinational word access on a cache line: extracts one 32-bit word for
// loads and produces a copy of the line with that word replaced for stores.
//  line_i   : source line
//  word_i   : word index within the line
//  wdata_i  : replacement word
//  rdata_o  : selected word of line_i
//  merged_o : line_i with word word_i replaced by wdata_i
// ----------------------------------------------------------------------------
module dcache_word_sel
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [WSEL_W-1:0] word_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic [LINE_W-1:0] merged_o
);

    // Word extract and word merge at the selected word offset
    always_comb begin
        rdata_o  = line_i[int'(word_i) * WORD_W +: WORD_W];
        merged_o = line_i;
        merged_o[int'(word_i) * WORD_W +: WORD_W] = wdata_i;
    end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// ----------------------------------------------------------------------------
// dcache_miss_ctrl
// Initiator side of the 2-way dcache SRAM interface. Hits complete in the
// request cycle with no stall. A miss stalls the CPU, writes back a dirty
// LRU victim, refills the line from data memory and returns to IDLE where
// the still-held CPU request replays as a hit.
//  clk_i, rst_n_i             : clock, async active-low reset
//  cpu_*                      : MEM-stage request (addr, store data, read/write)
//                               and response (load data, stall)
//  sram_*_o                   : set index, tag word, line, enable, write
//  sram_*_i                   : hit flag and matching line/tag, or LRU victim
//  mem_*_o                    : line-wide memory request held until ack
//  mem_data_i, mem_ack_i      : refill data and one-cycle completion pulse
// ----------------------------------------------------------------------------
module dcache_miss_ctrl
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [WORD_W-1:0]     cpu_data_i,
    input  logic                  cpu_MemRead_i,
    input  logic                  cpu_MemWrite_i,
    output logic [WORD_W-1:0]     cpu_data_o,
    output logic                  cpu_stall_o,
    output logic [IDX_W-1:0]      sram_addr_o,
    output logic [SRAM_TAG_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0]     sram_data_o,
    output logic                  sram_enable_o,
    output logic                  sram_write_o,
    input  logic [SRAM_TAG_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0]     sram_data_i,
    input  logic                  sram_hit_i,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [LINE_W-1:0]     mem_data_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    input  logic [LINE_W-1:0]     mem_data_i,
    input  logic                  mem_ack_i
);

    state_e             state_q, state_d;
    logic [LADDR_W-1:0] addr_q;          // latched {tag, index} of the missing access
    logic [TAG_W-1:0]   victim_tag_q;
    logic [LINE_W-1:0]  victim_line_q;
    logic               victim_dirty_q;  // victim both valid and dirty
    logic               latch_en_s;

    logic [TAG_W-1:0]   cpu_tag_s;
    logic [IDX_W-1:0]   cpu_idx_s;
    logic [TAG_W-1:0]   miss_tag_s;
    logic [IDX_W-1:0]   miss_idx_s;
    logic               req_s;
    logic               is_store_s;
    logic [LINE_W-1:0]  merged_line_s;

    // Byte-offset bits below word granularity carry no information here
    logic               unused_byte_off_s;
    assign unused_byte_off_s = ^cpu_addr_i[1:0];

    assign cpu_tag_s  = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign cpu_idx_s  = cpu_addr_i[OFF_W +: IDX_W];
    assign miss_tag_s = addr_q[LADDR_W-1 -: TAG_W];
    assign miss_idx_s = addr_q[IDX_W-1:0];
    assign req_s      = cpu_MemRead_i | cpu_MemWrite_i;
    // A store wins when both request lines are high
    assign is_store_s = cpu_MemWrite_i;

    dcache_word_sel u_word_sel (
        .line_i   (sram_data_i),
        .word_i   (cpu_addr_i[OFF_W-1:2]),
        .wdata_i  (cpu_data_i),
        .rdata_o  (cpu_data_o),
        .merged_o (merged_line_s)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Miss context captured in the cycle the miss is detected
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q         <= {LADDR_W{1'b0}};
            victim_tag_q   <= {TAG_W{1'b0}};
            victim_line_q  <= {LINE_W{1'b0}};
            victim_dirty_q <= 1'b0;
        end else if (latch_en_s) begin
            addr_q         <= cpu_addr_i[ADDR_W-1:OFF_W];
            victim_tag_q   <= sram_tag_i[TAG_W-1:0];
            victim_line_q  <= sram_data_i;
            victim_dirty_q <= sram_tag_i[TAG_VALID_BIT] & sram_tag_i[TAG_DIRTY_BIT];
        end else begin
            addr_q         <= addr_q;
            victim_tag_q   <= victim_tag_q;
            victim_line_q  <= victim_line_q;
            victim_dirty_q <= victim_dirty_q;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        latch_en_s    = 1'b0;
        cpu_stall_o   = 1'b1;
        sram_addr_o   = miss_idx_s;
        sram_tag_o    = make_tag(1'b0, 1'b0, miss_tag_s);
        sram_data_o   = merged_line_s;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        mem_addr_o    = {miss_tag_s, miss_idx_s, {OFF_W{1'b0}}};
        mem_data_o    = victim_line_q;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sram_addr_o = cpu_idx_s;
                sram_tag_o  = make_tag(1'b0, 1'b0, cpu_tag_s);
                if (req_s) begin
                    sram_enable_o = 1'b1;
                    if (sram_hit_i) begin
                        cpu_stall_o = 1'b0;
                        if (is_store_s) begin
                            sram_write_o = 1'b1;
                            sram_tag_o   = make_tag(1'b1, 1'b1, cpu_tag_s);
                            sram_data_o  = merged_line_s;
                        end else begin
                            sram_write_o = 1'b0;
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        latch_en_s  = 1'b1;
                        state_d     = ST_MISS;
                    end
                end else begin
                    cpu_stall_o = 1'b0;
                end
            end
            ST_MISS: begin
                if (victim_dirty_q) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {victim_tag_q, miss_idx_s, {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    state_d = ST_REFILL;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_REFILL: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b0;
                if (mem_ack_i) begin
                    sram_enable_o = 1'b1;
                    sram_write_o  = 1'b1;
                    sram_tag_o    = make_tag(1'b1, 1'b0, miss_tag_s);
                    sram_data_o   = mem_data_i;
                    state_d       = ST_REFILL_DONE;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL_DONE: begin
                // Gives the SRAM a cycle to present the new line before replay
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dcache_miss_ctrl
// Directed bench for dcache_miss_ctrl. The SRAM and data memory are driven
// directly as directed vectors; expected values are hand-derived constants.
// ----------------------------------------------------------------------------
module tb_dcache_miss_ctrl;

    logic         clk;
    logic         rst_n;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_rd;
    logic         cpu_wr;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_in;
    logic [255:0] sram_data_in;
    logic         sram_hit;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_rdata;
    logic         mem_ack;

    int vectors;
    int errors;

    dcache_miss_ctrl dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .cpu_addr_i     (cpu_addr),
        .cpu_data_i     (cpu_wdata),
        .cpu_MemRead_i  (cpu_rd),
        .cpu_MemWrite_i (cpu_wr),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .sram_addr_o    (sram_addr_o),
        .sram_tag_o     (sram_tag_o),
        .sram_data_o    (sram_data_o),
        .sram_enable_o  (sram_enable_o),
        .sram_write_o   (sram_write_o),
        .sram_tag_i     (sram_tag_in),
        .sram_data_i    (sram_data_in),
        .sram_hit_i     (sram_hit),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_data_i     (mem_rdata),
        .mem_ack_i      (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line whose word i holds base | i
    function automatic logic [255:0] line_pat(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base | 32'(i);
        return l;
    endfunction

    // Present a missing access, then play memory until the replay hits
    task automatic run_miss(input logic [31:0] addr, input logic [24:0] vtag,
                            input logic [255:0] vline, input int lat, input bit wb,
                            input logic [31:0] wb_addr, input logic [31:0] rd_addr,
                            input logic [255:0] fill, input int exp_stalls);
        int req_cyc;
        int acks;
        int stalls;
        bit in_wb;
        bit filled;
        bit fill_ack_prev;
        req_cyc = 0; acks = 0; stalls = 1; in_wb = wb; filled = 1'b0; fill_ack_prev = 1'b0;

        @(negedge clk);
        cpu_addr = addr; cpu_rd = 1'b1; cpu_wr = 1'b0;
        sram_hit = 1'b0; sram_tag_in = vtag; sram_data_in = vline;
        #1;
        chk("miss_stall_now", cpu_stall_o, 1'b1);
        chk("miss_no_mem_yet", mem_enable_o, 1'b0);

        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = '0;
            if (filled) begin
                sram_hit = 1'b1; sram_tag_in = {1'b1, 1'b0, addr[31:9]}; sram_data_in = fill;
            end else begin
                // Victim presented only in the miss cycle; scrambled afterwards
                sram_hit = 1'b0; sram_tag_in = 25'h0; sram_data_in = {256{1'b1}};
            end
            #1;
            if (!cpu_stall_o) break;
            stalls++;
            if (fill_ack_prev) begin
                chk("mem_en_drop", mem_enable_o, 1'b0);
                chk("done_no_write", sram_write_o, 1'b0);
                fill_ack_prev = 1'b0;
            end
            if (mem_enable_o) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    chk(in_wb ? "wb_write" : "rf_write", mem_write_o, in_wb);
                    chk(in_wb ? "wb_addr" : "rf_addr", mem_addr_o, in_wb ? wb_addr : rd_addr);
                    if (in_wb) chk("wb_data", mem_data_o, vline);
                end
                if (req_cyc == lat) begin
                    mem_ack = 1'b1;
                    if (!in_wb) mem_rdata = fill;
                    #1;
                    if (!in_wb) begin
                        chk("fill_write", sram_write_o, 1'b1);
                        chk("fill_tag", sram_tag_o, {1'b1, 1'b0, addr[31:9]});
                        chk("fill_data", sram_data_o, fill);
                        chk("fill_set", sram_addr_o, addr[8:5]);
                        filled = 1'b1;
                        fill_ack_prev = 1'b1;
                    end else begin
                        chk("wb_no_sram_write", sram_write_o, 1'b0);
                    end
                    in_wb = 1'b0; req_cyc = 0; acks++;
                end
            end
        end
        chk("miss_resolved", cpu_stall_o, 1'b0);
        chk("ack_count", 32'(acks), wb ? 32'd2 : 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    endtask

    initial begin
        logic [255:0] line;
        logic [255:0] exp_line;
        vectors = 0; errors = 0;
        rst_n = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        sram_tag_in = 25'h0; sram_data_in = '0; sram_hit = 1'b0; mem_rdata = '0; mem_ack = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_stall", cpu_stall_o, 1'b0);
        chk("rst_mem_en", mem_enable_o, 1'b0);
        chk("rst_mem_wr", mem_write_o, 1'b0);
        chk("rst_sram_wr", sram_write_o, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // 1: load hit, set 3 tag 0x12 word 2
        @(negedge clk);
        line = line_pat(32'h10000000); line[95:64] = 32'hDEADBEEF;
        cpu_addr = 32'h00002468; cpu_rd = 1'b1; sram_hit = 1'b1;
        sram_tag_in = {1'b1, 1'b0, 23'h12}; sram_data_in = line;
        #1;
        chk("t1_data", cpu_data_o, 32'hDEADBEEF);
        chk("t1_stall", cpu_stall_o, 1'b0);
        chk("t1_set", sram_addr_o, 4'h3);
        chk("t1_en", sram_enable_o, 1'b1);
        chk("t1_no_write", sram_write_o, 1'b0);
        @(negedge clk); cpu_rd = 1'b0; sram_hit = 1'b0; #1;
        chk("t1_idle_stall", cpu_stall_o, 1'b0);
        chk("t1_idle_en", sram_enable_o, 1'b0);

        // 2: clean miss, memory answers on the 10th request cycle
        run_miss(32'h00002468, {1'b1, 1'b0, 23'h7}, line_pat(32'h70000000), 10, 1'b0,
                 32'h0, 32'h00002460, line_pat(32'hA0000000), 13);
        chk("t2_load_data", cpu_data_o, 32'hA0000002);
        @(negedge clk); cpu_rd = 1'b0; sram_hit = 1'b0;

        // 3: dirty victim tag 0x7 in set 3 -> writeback 0xE60, then refill 0x4460
        run_miss(32'h00004468, {1'b1, 1'b1, 23'h7}, line_pat(32'hB0000000), 4, 1'b1,
                 32'h00000E60, 32'h00004460, line_pat(32'hC0000000), 11);
        chk("t3_load_data", cpu_data_o, 32'hC0000002);
        @(negedge clk); cpu_rd = 1'b0; sram_hit = 1'b0;

        // 4: store hit word 5
        @(negedge clk);
        line = line_pat(32'h50000000);
        exp_line = line; exp_line[191:160] = 32'hCAFEF00D;
        cpu_addr = 32'h00002474; cpu_wr = 1'b1; cpu_wdata = 32'hCAFEF00D;
        sram_hit = 1'b1; sram_tag_in = {1'b1, 1'b0, 23'h12}; sram_data_in = line;
        #1;
        chk("t4_stall", cpu_stall_o, 1'b0);
        chk("t4_write", sram_write_o, 1'b1);
        chk("t4_data", sram_data_o, exp_line);
        chk("t4_tag", sram_tag_o, {1'b1, 1'b1, 23'h12});
        chk("t4_set", sram_addr_o, 4'h3);
        chk("t4_mem_en", mem_enable_o, 1'b0);
        @(negedge clk); cpu_wr = 1'b0; sram_hit = 1'b0;

        // 5: reset asserted in REFILL before the ack
        @(negedge clk);
        cpu_addr = 32'h00008468; cpu_rd = 1'b1; sram_hit = 1'b0;
        sram_tag_in = 25'h0; sram_data_in = '0;
        @(negedge clk); #1;
        chk("t5_miss_state", mem_enable_o, 1'b0);
        @(negedge clk); #1;
        chk("t5_refill_en", mem_enable_o, 1'b1);
        chk("t5_refill_rd", mem_write_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; cpu_rd = 1'b0; mem_ack = 1'b1; mem_rdata = line_pat(32'hE0000000);
        #1;
        chk("t5_en_drop", mem_enable_o, 1'b0);
        chk("t5_no_write", sram_write_o, 1'b0);
        chk("t5_idle_stall", cpu_stall_o, 1'b0);
        @(negedge clk); rst_n = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk); #1;
        chk("t5_stays_idle", mem_enable_o, 1'b0);

        // 6: spurious ack in IDLE with both read and write high -> store
        @(negedge clk);
        line = line_pat(32'h60000000);
        exp_line = line; exp_line[31:0] = 32'h11223344;
        cpu_addr = 32'h00002460; cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_wdata = 32'h11223344;
        sram_hit = 1'b1; sram_tag_in = {1'b1, 1'b0, 23'h12}; sram_data_in = line; mem_ack = 1'b1;
        #1;
        chk("t6_write", sram_write_o, 1'b1);
        chk("t6_data", sram_data_o, exp_line);
        chk("t6_tag", sram_tag_o, {1'b1, 1'b1, 23'h12});
        chk("t6_mem_en", mem_enable_o, 1'b0);
        chk("t6_stall", cpu_stall_o, 1'b0);
        @(negedge clk); cpu_rd = 1'b0; cpu_wr = 1'b0; sram_hit = 1'b0; mem_ack = 1'b0; #1;
        chk("t6_after_en", mem_enable_o, 1'b0);
        chk("t6_after_wr", mem_write_o, 1'b0);
        chk("t6_after_stall", cpu_stall_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
